// File: rtl/collision_scanner.sv
// Bullet-vs-asteroid AABB collision scanner.
// Snapshots all objects on start, then tests one (bullet, asteroid) pair per clock.
module collision_scanner #(
    parameter int NUM_BULLETS   = 4,
    parameter int NUM_ASTEROIDS = 8,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int BULLET_SIZE   = 2,
    parameter int ASTEROID_SIZE = 8,
    parameter int CNT_W         = 6
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [NUM_BULLETS-1:0]         bullet_valid,
    input  logic [NUM_BULLETS*X_W-1:0]     bullet_x,
    input  logic [NUM_BULLETS*Y_W-1:0]     bullet_y,
    input  logic [NUM_ASTEROIDS-1:0]       ast_valid,
    input  logic [NUM_ASTEROIDS*X_W-1:0]   ast_x,
    input  logic [NUM_ASTEROIDS*Y_W-1:0]   ast_y,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_BULLETS-1:0]         bullet_hit,
    output logic [NUM_ASTEROIDS-1:0]       ast_hit,
    output logic [CNT_W-1:0]               hit_count
);

    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int JW = (NUM_ASTEROIDS > 1) ? $clog2(NUM_ASTEROIDS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [NUM_BULLETS-1:0]       snap_bv;
    logic [NUM_BULLETS*X_W-1:0]   snap_bx;
    logic [NUM_BULLETS*Y_W-1:0]   snap_by;
    logic [NUM_ASTEROIDS-1:0]     snap_av;
    logic [NUM_ASTEROIDS*X_W-1:0] snap_ax;
    logic [NUM_ASTEROIDS*Y_W-1:0] snap_ay;

    logic [IW-1:0] i_idx;
    logic [JW-1:0] j_idx;
    // Set once the last pair is evaluated; SCAN then idles one cycle before DONE.
    logic          tail;

    logic [X_W-1:0] bx, ax;
    logic [Y_W-1:0] by, ay;
    logic [X_W:0]   bx_w, ax_w, bx_end, ax_end;
    logic [Y_W:0]   by_w, ay_w, by_end, ay_end;
    logic           overlap, pair_hit, last_pair, eval;

    always_comb begin
        bx = snap_bx[i_idx*X_W +: X_W];
        by = snap_by[i_idx*Y_W +: Y_W];
        ax = snap_ax[j_idx*X_W +: X_W];
        ay = snap_ay[j_idx*Y_W +: Y_W];
        bx_w   = {1'b0, bx};
        by_w   = {1'b0, by};
        ax_w   = {1'b0, ax};
        ay_w   = {1'b0, ay};
        bx_end = bx_w + (X_W+1)'(BULLET_SIZE);
        by_end = by_w + (Y_W+1)'(BULLET_SIZE);
        ax_end = ax_w + (X_W+1)'(ASTEROID_SIZE);
        ay_end = ay_w + (Y_W+1)'(ASTEROID_SIZE);
        overlap = (bx_w < ax_end) && (ax_w < bx_end) &&
                  (by_w < ay_end) && (ay_w < by_end);
        eval      = (state == SCAN) && !tail;
        pair_hit  = eval && snap_bv[i_idx] && snap_av[j_idx] && overlap;
        last_pair = (i_idx == IW'(NUM_BULLETS-1)) &&
                    (j_idx == JW'(NUM_ASTEROIDS-1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (tail) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            snap_bv    <= '0;
            snap_bx    <= '0;
            snap_by    <= '0;
            snap_av    <= '0;
            snap_ax    <= '0;
            snap_ay    <= '0;
            i_idx      <= '0;
            j_idx      <= '0;
            tail       <= 1'b0;
            bullet_hit <= '0;
            ast_hit    <= '0;
            hit_count  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                snap_bv    <= bullet_valid;
                snap_bx    <= bullet_x;
                snap_by    <= bullet_y;
                snap_av    <= ast_valid;
                snap_ax    <= ast_x;
                snap_ay    <= ast_y;
                i_idx      <= '0;
                j_idx      <= '0;
                tail       <= 1'b0;
                bullet_hit <= '0;
                ast_hit    <= '0;
                hit_count  <= '0;
            end else if (eval) begin
                if (pair_hit) begin
                    bullet_hit[i_idx] <= 1'b1;
                    ast_hit[j_idx]    <= 1'b1;
                    if (hit_count != '1)
                        hit_count <= hit_count + 1'b1;
                end
                if (last_pair) begin
                    tail <= 1'b1;
                end else if (j_idx == JW'(NUM_ASTEROIDS-1)) begin
                    j_idx <= '0;
                    i_idx <= i_idx + 1'b1;
                end else begin
                    j_idx <= j_idx + 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
